// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  localparam logic [3:0] BIT_LAST   = 4'd10;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } dec_state_e;

  function automatic logic is_ignored(
    input logic [7:0] b
  );
    return (b == 8'h00) || (b == 8'hAA) ||
           (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: sync, glitch filter, 11-bit framing,
// odd parity check and partial-frame timeout.
import ps2_pkg::*;

module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          fall;
  logic [10:0]   frame;
  logic          frame_ok;

  // A level change is adopted only once the new level has
  // been seen for FILTER_LEN samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1))
        filt_d = clk_s2_q;
      else
        fcnt_d = fcnt_q + FW'(1);
    end
    fall = filt_q & ~filt_d;
  end

  // The stop bit is not stored; it is the live sample.
  assign frame    = {dat_s2_q, shift_q};
  assign frame_ok = ~frame[0] & (^frame[9:1])
                  & frame[10];
  assign rx_byte  = frame[8:1];

  always_comb begin
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    tcnt_d   = tcnt_q;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (fall) begin
      tcnt_d  = '0;
      shift_d = {dat_s2_q, shift_q[9:1]};
      if (bcnt_q == BIT_LAST) begin
        bcnt_d   = '0;
        rx_valid = frame_ok;
        rx_err   = ~frame_ok;
      end else begin
        bcnt_d = bcnt_q + 4'd1;
      end
    end else if (bcnt_q != 4'd0) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        tcnt_d = '0;
        bcnt_d = '0;
        rx_err = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: turns received bytes into
// make/break events with E0 extension and E1 pause skip.
import ps2_pkg::*;

module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  dec_state_e st_q, st_d;
  logic [2:0] skip_q, skip_d;
  logic       strobe_q, strobe_d;
  logic       err_q, err_d;
  logic       pressed_q, pressed_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       emit, e_p, e_x;

  always_comb begin
    st_d   = st_q;
    skip_d = skip_q;
    emit   = 1'b0;
    e_p    = 1'b0;
    e_x    = 1'b0;
    if (rx_err) begin
      st_d   = ST_IDLE;
      skip_d = '0;
    end else if (rx_valid) begin
      unique case (st_q)
        ST_IDLE: begin
          unique case (1'b1)
            rx_byte == PS2_E0: st_d = ST_EXT;
            rx_byte == PS2_F0: st_d = ST_BRK;
            rx_byte == PS2_E1: begin
              st_d   = ST_PAUSE;
              skip_d = PAUSE_SKIP;
            end
            is_ignored(rx_byte): st_d = ST_IDLE;
            default: begin
              emit = 1'b1;
              e_p  = 1'b1;
            end
          endcase
        end
        ST_EXT: begin
          if (rx_byte == PS2_F0) begin
            st_d = ST_EXTBRK;
          end else begin
            emit = 1'b1;
            e_p  = 1'b1;
            e_x  = 1'b1;
            st_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit = 1'b1;
          st_d = ST_IDLE;
        end
        ST_EXTBRK: begin
          emit = 1'b1;
          e_x  = 1'b1;
          st_d = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d = '0;
            st_d   = ST_IDLE;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    strobe_d  = emit;
    err_d     = rx_err;
    pressed_d = pressed_q;
    ext_d     = ext_q;
    code_d    = code_q;
    if (emit) begin
      pressed_d = e_p;
      ext_d     = e_x;
      code_d    = rx_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      skip_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      pressed_q <= 1'b0;
      ext_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      st_q      <= st_d;
      skip_q    <= skip_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      pressed_q <= pressed_d;
      ext_q     <= ext_d;
      code_q    <= code_d;
    end
  end

  assign key_strobe   = strobe_q;
  assign frame_error  = err_q;
  assign key_pressed  = pressed_q;
  assign key_extended = ext_q;
  assign key_code     = code_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scancode sequences,
// parity/timeout errors, glitch rejection and reset.
module tb_ps2_key_decoder;

  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_error;

  int vecs = 0;
  int errs = 0;

  int n_strobe = 0;
  int n_err    = 0;
  bit both_seen = 1'b0;

  ps2_key_decoder #(
    .FILTER_LEN(8),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_strobe  (key_strobe),
    .key_pressed (key_pressed),
    .key_extended(key_extended),
    .key_code    (key_code),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe === 1'b1)  n_strobe++;
    if (frame_error === 1'b1) n_err++;
    if (key_strobe === 1'b1 && frame_error === 1'b1)
      both_seen = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f,
                           input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      hold(HALF);
      ps2_clk = 1'b0;
      hold(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit bad);
    logic par;
    par = bad ? (^b) : ~(^b);
    send_bits({1'b1, par, b, 1'b0}, 11);
    hold(40);
  endtask

  task automatic chk_int(input string nm,
                         input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_key(input string nm,
                         input logic [7:0] c,
                         input logic p, input logic x);
    vecs++;
    if ({key_code, key_pressed, key_extended}
        !== {c, p, x}) begin
      errs++;
      $display("FAIL %s got code=%h p=%b x=%b exp code=%h p=%b x=%b",
               nm, key_code, key_pressed, key_extended,
               c, p, x);
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    hold(5);
    vecs++;
    if ({key_strobe, frame_error} !== 2'b00) begin
      errs++;
      $display("FAIL reset_pulses got=%b exp=00",
               {key_strobe, frame_error});
    end
    chk_key("reset_key", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    hold(5);
  endtask

  task automatic test_make;
    int s0 = n_strobe;
    int e0 = n_err;
    send_byte(8'h1C, 1'b0);
    chk_int("make_strobes", n_strobe - s0, 1);
    chk_int("make_errors", n_err - e0, 0);
    chk_key("make_1c", 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_ext_break;
    int s0 = n_strobe;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk_int("extbrk_strobes", n_strobe - s0, 1);
    chk_key("extbrk_75", 8'h75, 1'b0, 1'b1);
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    int s0 = n_strobe;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
            8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++)
      send_byte(seq[i], 1'b0);
    chk_int("pause_strobes", n_strobe - s0, 0);
    send_byte(8'h1C, 1'b0);
    chk_int("pause_after", n_strobe - s0, 1);
    chk_key("pause_1c", 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_parity;
    int s0 = n_strobe;
    int e0 = n_err;
    send_byte(8'h1C, 1'b1);
    chk_int("par_errors", n_err - e0, 1);
    chk_int("par_strobes", n_strobe - s0, 0);
    send_byte(8'h1C, 1'b0);
    chk_int("par_recover", n_strobe - s0, 1);
  endtask

  task automatic test_timeout;
    int s0 = n_strobe;
    int e0 = n_err;
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
    hold(TO + 10);
    chk_int("to_errors", n_err - e0, 1);
    chk_int("to_strobes", n_strobe - s0, 0);
    send_byte(8'h29, 1'b0);
    chk_int("to_recover", n_strobe - s0, 1);
    chk_key("to_29", 8'h29, 1'b1, 1'b0);
  endtask

  task automatic test_glitch;
    int s0 = n_strobe;
    int e0 = n_err;
    ps2_clk = 1'b0;
    hold(3);
    ps2_clk = 1'b1;
    hold(40);
    send_byte(8'h1C, 1'b0);
    chk_int("glitch_errors", n_err - e0, 0);
    chk_int("glitch_strobes", n_strobe - s0, 1);
    chk_key("glitch_1c", 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int s0;
    send_byte(8'h2A, 1'b0);
    send_byte(8'hF0, 1'b0);
    reset = 1'b1;
    hold(5);
    chk_key("rst_clear", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    hold(5);
    s0 = n_strobe;
    send_byte(8'h1C, 1'b0);
    chk_int("rst_strobes", n_strobe - s0, 1);
    chk_key("rst_make", 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_fake_shift;
    int s0 = n_strobe;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h12, 1'b0);
    chk_key("fs_make", 8'h12, 1'b1, 1'b1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h12, 1'b0);
    chk_key("fs_break", 8'h12, 1'b0, 1'b1);
    chk_int("fs_strobes", n_strobe - s0, 2);
  endtask

  task automatic test_ignored;
    int s0 = n_strobe;
    send_byte(8'h33, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    send_byte(8'h00, 1'b0);
    chk_int("ign_strobes", n_strobe - s0, 1);
    chk_key("ign_held", 8'h33, 1'b1, 1'b0);
  endtask

  task automatic test_err_clears_prefix;
    int s0 = n_strobe;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h1C, 1'b0);
    chk_int("errpfx_strobes", n_strobe - s0, 1);
    chk_key("errpfx_1c", 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_exclusive;
    chk_int("strobe_err_excl", int'(both_seen), 0);
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_pause();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_fake_shift();
    test_ignored();
    test_err_clears_prefix();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles without a filtered falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port key_strobe, output, 1 bit: one-cycle pulse marking a new key event.
REQ-008 SHALL have port key_pressed, output, 1 bit: 1 = make, 0 = break; valid with key_strobe and held until the next strobe.
REQ-009 SHALL have port key_extended, output, 1 bit: 1 if the event was prefixed by E0; held like key_pressed.
REQ-010 SHALL have port key_code, output, 8 bits: set-2 scancode without prefixes; held like key_pressed.
REQ-011 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a rejected or timed-out frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any other use.
REQ-013 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronized samples; shorter glitches SHALL be ignored.
REQ-014 SHALL sample synchronized ps2_data on each filtered-clock falling edge into an 11-bit frame: start, data0..7 (LSB first), parity, stop.
REQ-015 SHALL count bits 0..10 and return the counter to 0 after the 11th bit.
REQ-016 SHALL accept a frame only when start=0, the 9 data+parity bits have odd parity, and stop=1; otherwise it SHALL pulse frame_error for one cycle and discard the byte.
REQ-017 SHALL, when the bit counter is nonzero and TIMEOUT cycles pass with no falling edge, zero the counter, pulse frame_error, and discard the partial frame.
REQ-018 SHALL have decoder states IDLE, EXT, BRK, EXTBRK, PAUSE.
REQ-019 SHALL handle each accepted byte in IDLE as: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7; 00/AA/EE/FA/FE/FF -> ignored, stay IDLE; any other byte -> emit (pressed=1, ext=0).
REQ-020 SHALL handle each accepted byte in EXT as: F0 -> EXTBRK; any other byte -> emit (pressed=1, ext=1) and return to IDLE.
REQ-021 SHALL, in BRK, emit (pressed=0, ext=0) for any byte and return to IDLE.
REQ-022 SHALL, in EXTBRK, emit (pressed=0, ext=1) for any byte and return to IDLE.
REQ-023 SHALL, in PAUSE, decrement the skip count on each byte, emit nothing, and enter IDLE when the count reaches 0 (the 8-byte E1 sequence produces no events).
REQ-024 SHALL emit E0-12 and E0-F0-12 (fake shift) as ordinary extended events with code 12.
REQ-025 SHALL assert key_strobe exactly one clk cycle after the cycle in which the accepted stop bit is sampled, updating key_code/key_pressed/key_extended in that same cycle.
REQ-026 SHALL return the decoder to IDLE (PAUSE count cleared) on any frame_error, emitting no event.
REQ-027 SHALL keep key_strobe and frame_error mutually exclusive in any cycle.

Reset
REQ-028 SHALL, while reset=1, hold key_strobe, key_pressed, key_extended, key_code and frame_error at 0, hold the decoder in IDLE, and clear the bit counter, timeout counter, filter state and PAUSE count.
REQ-029 SHALL set the filtered clock and synchronizers to 1 (idle bus) during reset.
REQ-030 SHALL discard any frame in progress when reset is asserted mid-frame; the first edges after release SHALL start a new frame.

Structure
REQ-031 SHALL take the prefix constants (E0, F0, E1), the ignored-byte codes and the decoder state encoding from shared package ps2_pkg.
REQ-032 SHALL instantiate one sub-module, ps2_rx, which contains synchronizer, filter, framing, parity and timeout and outputs byte/valid/error to the decoder FSM.

Verification
REQ-033 SHALL verify: frame for byte 1C, valid parity -> one key_strobe, key_code=1C, pressed=1, extended=0.
REQ-034 SHALL verify: bytes E0 F0 75 -> exactly one strobe, code=75, pressed=0, extended=1.
REQ-035 SHALL verify: E1 14 77 E1 F0 14 F0 77 -> zero strobes; a following 1C then produces make 1C.
REQ-036 SHALL verify: byte 1C with wrong parity -> frame_error pulse and no strobe; a following valid 1C produces a strobe.
REQ-037 SHALL verify: 5 falling edges, then idle for TIMEOUT+10 cycles -> one frame_error; a following full frame 29 produces make 29.
REQ-038 SHALL verify: a 3-cycle ps2_clk glitch with FILTER_LEN=8 -> no bit sampled; reset asserted after F0 and before 1C -> the 1C decodes as make, not break.
